// File: rtl/otter_ir_pipe_if.sv
// Fetch-side and stage-output bundle for the OTTER IR/PC pipeline.
// The master side drives fetch and clear; the slave side is the pipe.
interface otter_ir_pipe_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      fetch_ir;
  logic [31:0]      fetch_pc;
  logic             fetch_vld;
  logic             clear;
  logic             pc_write;
  logic             stall;
  logic [31:0]      dec_ir;
  logic [31:0]      dec_pc;
  logic [31:0]      exe_ir;
  logic [31:0]      exe_pc;
  logic [31:0]      mem_ir;
  logic [31:0]      mem_pc;
  logic [31:0]      wb_ir;
  logic [31:0]      wb_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output fetch_ir, fetch_pc, fetch_vld, clear,
    input  pc_write, stall,
    input  dec_ir, dec_pc, exe_ir, exe_pc,
    input  mem_ir, mem_pc, wb_ir, wb_pc,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  fetch_ir, fetch_pc, fetch_vld, clear,
    output pc_write, stall,
    output dec_ir, dec_pc, exe_ir, exe_pc,
    output mem_ir, mem_pc, wb_ir, wb_pc,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/otter_ir_pipe.sv
// OTTER IR/PC register chain DEC->EXE->MEM->WB with load-use
// stall, decode-stage squash and saturating event counters.
module otter_ir_pipe #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input logic           clk,
  input logic           reset_n,
  otter_ir_pipe_if.slave pif
);
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } stage_t;

  localparam stage_t BUBBLE = '{ir: NOP_INSTR, pc: 32'h0};

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  stage_t dec, exe, mem, wb;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [6:0] dec_op;
  logic [4:0] dec_rs1, dec_rs2, exe_rd;
  logic       use_rs1, use_rs2, stall;

  assign dec_op  = dec.ir[6:0];
  assign dec_rs1 = dec.ir[19:15];
  assign dec_rs2 = dec.ir[24:20];
  assign exe_rd  = exe.ir[11:7];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (1'b1)
      dec_op == OP_JALR,
      dec_op == OP_LOAD,
      dec_op == OP_IMM,
      dec_op == OP_SYS: use_rs1 = 1'b1;
      dec_op == OP_BRANCH,
      dec_op == OP_STORE,
      dec_op == OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // LUI/AUIPC/JAL fall to default: no register sources.
  assign stall = (exe.ir[6:0] == OP_LOAD) && (exe_rd != 5'd0) &&
                 ((use_rs1 && dec_rs1 == exe_rd) ||
                  (use_rs2 && dec_rs2 == exe_rd));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec       <= BUBBLE;
      exe       <= BUBBLE;
      mem       <= BUBBLE;
      wb        <= BUBBLE;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mem <= exe;
      wb  <= mem;
      if (stall) begin
        exe <= BUBBLE;
        if (stall_cnt != '1)
          stall_cnt <= stall_cnt + 1'b1;
      end else begin
        exe <= dec;
        if (pif.clear) begin
          dec <= BUBBLE;
          if (flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
        end else if (pif.fetch_vld) begin
          dec <= '{ir: pif.fetch_ir, pc: pif.fetch_pc};
        end else begin
          dec <= BUBBLE;
        end
      end
    end
  end

  assign pif.stall     = stall;
  assign pif.pc_write  = ~stall;
  assign pif.dec_ir    = dec.ir;
  assign pif.dec_pc    = dec.pc;
  assign pif.exe_ir    = exe.ir;
  assign pif.exe_pc    = exe.pc;
  assign pif.mem_ir    = mem.ir;
  assign pif.mem_pc    = mem.pc;
  assign pif.wb_ir     = wb.ir;
  assign pif.wb_pc     = wb.pc;
  assign pif.stall_cnt = stall_cnt;
  assign pif.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_otter_ir_pipe.sv
// Bench for otter_ir_pipe: directed scenarios then random traffic
// against a four-slot array model of the pipeline.
module tb_otter_ir_pipe;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int CW = 16;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  otter_ir_pipe_if #(.CNT_W(CW)) pif ();

  otter_ir_pipe #(
    .NOP_INSTR(NOP),
    .CNT_W    (CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .pif    (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slot 0 = DEC, 1 = EXE, 2 = MEM, 3 = WB
  logic [31:0] m_ir [4];
  logic [31:0] m_pc [4];
  int          m_scnt;
  int          m_fcnt;
  localparam int SAT = (1 << CW) - 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic reads_rs1(logic [6:0] op);
    return op inside {7'b1100111, 7'b1100011, 7'b0000011,
                      7'b0100011, 7'b0010011, 7'b0110011,
                      7'b1110011};
  endfunction

  function automatic logic reads_rs2(logic [6:0] op);
    return op inside {7'b1100011, 7'b0100011, 7'b0110011};
  endfunction

  function automatic logic model_stall();
    logic [31:0] c, p;
    c = m_ir[0];
    p = m_ir[1];
    if (p[6:0] != 7'b0000011 || p[11:7] == 5'd0) return 1'b0;
    if (reads_rs1(c[6:0]) && c[19:15] == p[11:7]) return 1'b1;
    if (reads_rs2(c[6:0]) && c[24:20] == p[11:7]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ir[i] = NOP;
      m_pc[i] = 0;
    end
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  task automatic model_clock(logic [31:0] ir, logic [31:0] pc,
                             logic vld, logic clr, logic rst);
    logic st;
    st = model_stall();
    if (!rst) begin
      model_reset();
      return;
    end
    m_ir[3] = m_ir[2]; m_pc[3] = m_pc[2];
    m_ir[2] = m_ir[1]; m_pc[2] = m_pc[1];
    if (st) begin
      m_ir[1] = NOP; m_pc[1] = 0;
      if (m_scnt < SAT) m_scnt++;
    end else begin
      m_ir[1] = m_ir[0]; m_pc[1] = m_pc[0];
      if (clr) begin
        m_ir[0] = NOP; m_pc[0] = 0;
        if (m_fcnt < SAT) m_fcnt++;
      end else if (vld) begin
        m_ir[0] = ir; m_pc[0] = pc;
      end else begin
        m_ir[0] = NOP; m_pc[0] = 0;
      end
    end
  endtask

  task automatic check_all();
    check("dec_ir", pif.dec_ir, m_ir[0]);
    check("dec_pc", pif.dec_pc, m_pc[0]);
    check("exe_ir", pif.exe_ir, m_ir[1]);
    check("exe_pc", pif.exe_pc, m_pc[1]);
    check("mem_ir", pif.mem_ir, m_ir[2]);
    check("mem_pc", pif.mem_pc, m_pc[2]);
    check("wb_ir", pif.wb_ir, m_ir[3]);
    check("wb_pc", pif.wb_pc, m_pc[3]);
    check("stall_cnt", 32'(pif.stall_cnt), m_scnt);
    check("flush_cnt", 32'(pif.flush_cnt), m_fcnt);
  endtask

  task automatic step(logic [31:0] ir, logic [31:0] pc,
                      logic vld, logic clr, logic rst);
    logic es;
    pif.fetch_ir  = ir;
    pif.fetch_pc  = pc;
    pif.fetch_vld = vld;
    pif.clear     = clr;
    reset_n       = rst;
    #1;
    es = model_stall();
    check("stall", 32'(pif.stall), 32'(es));
    check("pc_write", 32'(pif.pc_write), 32'(!es));
    @(posedge clk);
    model_clock(ir, pc, vld, clr, rst);
    #1;
    check_all();
  endtask

  task automatic feed(logic [31:0] ir, logic [31:0] pc);
    step(ir, pc, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b1111111};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    pif.fetch_ir  = 32'h0;
    pif.fetch_pc  = 32'h0;
    pif.fetch_vld = 1'b0;
    pif.clear     = 1'b0;

    // T1 reset
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check("rst_dec_ir", pif.dec_ir, 32'h00000013);
    check("rst_wb_ir", pif.wb_ir, 32'h00000013);
    check("rst_exe_pc", pif.exe_pc, 32'h0);
    check("rst_scnt", 32'(pif.stall_cnt), 32'h0);
    check_all();

    // T2 flow
    feed(32'h00100093, 32'h0);
    feed(32'h00100093, 32'h4);
    feed(32'h00100093, 32'h8);
    feed(32'h00100093, 32'hC);
    check("t2_wb_pc0", pif.wb_pc, 32'h0);
    check("t2_dec_pc", pif.dec_pc, 32'hC);
    idle();
    check("t2_wb_pc4", pif.wb_pc, 32'h4);
    idle();
    check("t2_wb_pc8", pif.wb_pc, 32'h8);
    idle();
    check("t2_wb_pcC", pif.wb_pc, 32'hC);

    // T3 load-use
    feed(32'h0002A083, 32'h20);
    feed(32'h002081B3, 32'h24);
    check("t3_stall", 32'(pif.stall), 32'h1);
    check("t3_pcw", 32'(pif.pc_write), 32'h0);
    feed(32'h00100093, 32'h28);
    check("t3_exe_nop", pif.exe_ir, 32'h00000013);
    check("t3_dec_hold", pif.dec_ir, 32'h002081B3);
    check("t3_unstall", 32'(pif.stall), 32'h0);
    check("t3_scnt", 32'(pif.stall_cnt), 32'h1);
    feed(32'h00100093, 32'h28);

    // T4 no false stall
    feed(32'h0002A003, 32'h40);
    feed(32'h002001B3, 32'h44);
    check("t4_rd0", 32'(pif.stall), 32'h0);
    feed(32'h0002A083, 32'h48);
    feed(32'h000010B7, 32'h4C);
    check("t4_lui", 32'(pif.stall), 32'h0);

    // T5 flush
    feed(32'h00000063, 32'h10);
    step(32'h00100093, 32'h14, 1'b1, 1'b1, 1'b1);
    check("t5_exe_pc", pif.exe_pc, 32'h10);
    check("t5_dec_ir", pif.dec_ir, 32'h00000013);
    check("t5_dec_pc", pif.dec_pc, 32'h0);
    check("t5_fcnt", 32'(pif.flush_cnt), 32'h1);

    // T6 stall with clear, then reset during stall
    feed(32'h0002A083, 32'h30);
    feed(32'h002081B3, 32'h34);
    check("t6_stall", 32'(pif.stall), 32'h1);
    step(32'h00100093, 32'h38, 1'b1, 1'b1, 1'b1);
    check("t6_dec_hold", pif.dec_ir, 32'h002081B3);
    check("t6_exe_nop", pif.exe_ir, 32'h00000013);
    check("t6_fcnt", 32'(pif.flush_cnt), 32'h1);
    feed(32'h00100093, 32'h38);
    feed(32'h0002A083, 32'h50);
    feed(32'h002081B3, 32'h54);
    check("t6b_stall", 32'(pif.stall), 32'h1);
    step(32'h00100093, 32'h58, 1'b1, 1'b0, 1'b0);
    check("t6b_dec", pif.dec_ir, 32'h00000013);
    check("t6b_exe", pif.exe_ir, 32'h00000013);
    check("t6b_mem", pif.mem_ir, 32'h00000013);
    check("t6b_wb", pif.wb_ir, 32'h00000013);
    check("t6b_scnt", 32'(pif.stall_cnt), 32'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(rand_instr(), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 63) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
